uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART `transmitter` instance between `N` byte producers. It sits directly in front of the transmitter's `send_req`/`data`/`busy` interface. It picks one pending requester, hands its byte to the transmitter, and holds off all other requesters until the frame (start, 8 data, stop) has completed. Fairness is guaranteed by a rotating priority pointer.

---
 rtl/uart_tx_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N byte producers.
// One frame is in flight at a time; the pointer moves past the owner once busy falls.
module uart_tx_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     grant,
  output logic             tx_send_req,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [IDX_W-1:0] owner,
  output logic             idle
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t           r_state, w_nextState;
  logic [N-1:0]     r_grant, w_nextGrant;
  logic             r_sendReq, w_nextSendReq;
  logic [7:0]       r_txData, w_nextTxData;
  logic [IDX_W-1:0] r_owner, w_nextOwner;
  logic [IDX_W-1:0] r_rrPtr, w_nextRrPtr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_winner;
  logic             w_found;

  // Scan upward from the rotating pointer, wrapping modulo N; the first set request wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_rrPtr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextGrant   = '0;
    w_nextSendReq = r_sendReq;
    w_nextTxData  = r_txData;
    w_nextOwner   = r_owner;
    w_nextRrPtr   = r_rrPtr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nextState           = ISSUE;
          w_nextGrant[w_winner] = 1'b1;
          w_nextSendReq         = 1'b1;
          w_nextTxData          = req_data[{w_winner, 3'b000} +: 8];
          w_nextOwner           = w_winner;
        end
      end
      ISSUE: begin
        if (tx_busy) begin
          w_nextState   = WAIT_DONE;
          w_nextSendReq = 1'b0;
        end
      end
      WAIT_DONE: begin
        // Pointer only advances once the frame is fully done, so a reset mid-frame restarts at 0.
        if (!tx_busy) begin
          w_nextState = IDLE;
          w_nextRrPtr = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_sendReq <= 1'b0;
      r_txData  <= 8'h00;
      r_owner   <= '0;
      r_rrPtr   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_grant   <= w_nextGrant;
      r_sendReq <= w_nextSendReq;
      r_txData  <= w_nextTxData;
      r_owner   <= w_nextOwner;
      r_rrPtr   <= w_nextRrPtr;
    end
  end

  assign grant       = r_grant;
  assign tx_send_req = r_sendReq;
  assign tx_data     = r_txData;
  assign owner       = r_owner;
  assign idle        = (r_state == IDLE);

endmodule
